// File: rtl/dsp_wb_pkg.sv
// rtl/dsp_wb_pkg.sv - Shared Wishbone cycle-type, burst-type and slave state definitions
// Used by the DSP scratch RAM slave (optional DSP_RAM_WAIT_EN is handled in the top).
package dsp_wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR = 2'b00;
  localparam logic [1:0] BTE_WRAP4  = 2'b01;
  localparam logic [1:0] BTE_WRAP8  = 2'b10;
  localparam logic [1:0] BTE_WRAP16 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLASSIC = 2'd1,
    ST_BURST   = 2'd2,
    ST_WAIT    = 2'd3
  } state_e;

  // Next burst word index: wrap modes only move the low log2(N) bits, linear carries freely.
  function automatic logic [31:0] wrap_next(input logic [31:0] idx, input logic [1:0] bte);
    logic [31:0] mask;
    unique case (bte)
      BTE_WRAP4:  mask = 32'h0000_0003;
      BTE_WRAP8:  mask = 32'h0000_0007;
      BTE_WRAP16: mask = 32'h0000_000F;
      default:    mask = 32'hFFFF_FFFF;
    endcase
    return (idx & ~mask) | ((idx + 32'd1) & mask);
  endfunction

endpackage

// File: rtl/dsp_wb_ram_slave_if.sv
// rtl/dsp_wb_ram_slave_if.sv - Wishbone B3 bus bundle between the DSP master and the scratch RAM slave
// Signal names keep the slave-side _i/_o suffixes so both ends read the same as the slave port list.
interface dsp_wb_ram_slave_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  logic [aw-1:0] wb_adr_i;
  logic [dw-1:0] wb_dat_i;
  logic [3:0]    wb_sel_i;
  logic          wb_we_i;
  logic          wb_cyc_i;
  logic          wb_stb_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    wb_bte_i;
  logic [dw-1:0] wb_dat_o;
  logic          wb_ack_o;
  logic          wb_err_o;
  logic          wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/dsp_wb_ram_array.sv
// rtl/dsp_wb_ram_array.sv - DEPTH x 32 single-port synchronous RAM with byte-lane write enables
// Write-first: a read of the word being written returns the merged new data.
module dsp_wb_ram_array #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = mem[addr];
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) rdata_d[i*8 +: 8] = wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dsp_wb_ram_slave.sv
// rtl/dsp_wb_ram_slave.sv - Wishbone B3 scratch RAM slave: classic cycles and linear/wrap incrementing bursts
// Define DSP_RAM_WAIT_EN to insert WAIT_STATES cycles before classic acks and before the first burst beat.
module dsp_wb_ram_slave
  import dsp_wb_pkg::*;
#(
  parameter int              aw           = 32,
  parameter int              dw           = 32,
  parameter logic [aw-1:0]   BASE_ADDRESS = '0,
  parameter int              DEPTH        = 256,
  parameter int              WAIT_STATES  = 2
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  dsp_wb_ram_slave_if.slave wb,
  output logic              busy
);
  localparam int            IW   = $clog2(DEPTH);
  localparam logic [aw-1:0] SPAN = aw'(4 * DEPTH);
  localparam int            unused_cfg = dw + WAIT_STATES;

  state_e        state_q, state_d, go_state, start_state;
  logic [IW-1:0] idx_q, idx_d, go_idx;
  logic          ack_q, ack_d, err_q, err_d;
  logic          req, in_range, go, go_ok, ram_we;
  logic [aw-1:0] off;
  logic [31:0]   nxt, ram_rdata;
`ifdef DSP_RAM_WAIT_EN
  logic [7:0]    cnt_q, cnt_d;
`endif

  assign req      = wb.wb_cyc_i & wb.wb_stb_i;
  assign off      = wb.wb_adr_i - BASE_ADDRESS;
  assign in_range = (wb.wb_adr_i >= BASE_ADDRESS) && (off < SPAN);
  assign nxt      = wrap_next(32'(idx_q), wb.wb_bte_i);
  // An out-of-window burst start is answered with err and abandoned, like a classic error.
  assign start_state = (wb.wb_cti_i != CTI_INCR) ? ST_CLASSIC : (in_range ? ST_BURST : ST_IDLE);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    go       = 1'b0;
    go_ok    = 1'b0;
    go_idx   = off[IW+1:2];
    go_state = ST_IDLE;
`ifdef DSP_RAM_WAIT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
`ifdef DSP_RAM_WAIT_EN
          if (WAIT_STATES == 0) begin
            go       = 1'b1;
            go_ok    = in_range;
            go_state = start_state;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
`else
          go       = 1'b1;
          go_ok    = in_range;
          go_state = start_state;
`endif
        end
      end
      ST_CLASSIC: state_d = ST_IDLE;
      ST_BURST: begin
        if (req) begin
          go       = 1'b1;
          go_idx   = nxt[IW-1:0];
          go_ok    = !((wb.wb_bte_i == BTE_LINEAR) && (nxt >= 32'(DEPTH)));
          go_state = (go_ok && (wb.wb_cti_i == CTI_INCR)) ? ST_BURST : ST_IDLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
`ifdef DSP_RAM_WAIT_EN
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 8'(WAIT_STATES - 1)) begin
          go       = 1'b1;
          go_ok    = in_range;
          go_state = start_state;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
    if (go) begin
      state_d = go_state;
      idx_d   = go_idx;
      ack_d   = go_ok;
      err_d   = !go_ok;
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef DSP_RAM_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef DSP_RAM_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // The write is committed on the same edge that registers the beat's ack.
  assign ram_we = go & go_ok & wb.wb_we_i & ~wb_rst;

  dsp_wb_ram_array #(.DEPTH(DEPTH)) u_ram (
    .clk   (wb_clk),
    .addr  (go_idx),
    .we    (ram_we),
    .be    (wb.wb_sel_i),
    .wdata (wb.wb_dat_i),
    .rdata (ram_rdata)
  );

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = ack_q ? ram_rdata : '0;
  assign busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_dsp_wb_ram_slave.sv
// tb/tb_dsp_wb_ram_slave.sv - Directed bench for dsp_wb_ram_slave (default build, DSP_RAM_WAIT_EN undefined)
module tb_dsp_wb_ram_slave;
  import dsp_wb_pkg::*;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic [31:0] rd;
  int          vectors = 0;
  int          fails   = 0;
  int          exp_idx [4] = '{6, 7, 4, 5};

  dsp_wb_ram_slave_if #(.aw(32), .dw(32)) bus ();

  dsp_wb_ram_slave #(
    .aw(32), .dw(32), .BASE_ADDRESS(BASE), .DEPTH(DEPTH), .WAIT_STATES(2)
  ) dut (
    .wb_clk (clk),
    .wb_rst (rst),
    .wb     (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] wa(input int i);
    return BASE + 32'(4 * i);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                       input logic [31:0] dat, input logic [2:0] cti, input logic [1:0] bte);
    bus.wb_adr_i = adr;
    bus.wb_we_i  = we;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = dat;
    bus.wb_cti_i = cti;
    bus.wb_bte_i = bte;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
  endtask

  task automatic release_bus();
    bus.wb_adr_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_cti_i = CTI_CLASSIC;
    bus.wb_bte_i = BTE_LINEAR;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
  endtask

  task automatic classic(input string tag, input logic [31:0] adr, input logic we,
                         input logic [3:0] sel, input logic [31:0] wdat, input logic exp_ok,
                         output logic [31:0] rdat);
    drive(adr, we, sel, wdat, CTI_CLASSIC, BTE_LINEAR);
    step();
    chk({tag, " ack"}, 32'(bus.wb_ack_o), 32'(exp_ok));
    chk({tag, " err"}, 32'(bus.wb_err_o), 32'(!exp_ok));
    rdat = bus.wb_dat_o;
    release_bus();
    step();
    chk({tag, " ack/err/busy after"}, 32'({bus.wb_ack_o, bus.wb_err_o, busy}), 32'd0);
  endtask

  initial begin
    release_bus();
    repeat (3) step();
    chk("reset ack", 32'(bus.wb_ack_o), 32'd0);
    chk("reset err", 32'(bus.wb_err_o), 32'd0);
    chk("reset rty", 32'(bus.wb_rty_o), 32'd0);
    chk("reset dat", bus.wb_dat_o, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    step();

    // Classic write/read and byte lanes on word 4 (BASE+0x10)
    classic("wr deadbeef", wa(4), 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b1, rd);
    classic("rd deadbeef", wa(4), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd deadbeef data", rd, 32'hDEAD_BEEF);
    classic("wr full", wa(4), 1'b1, 4'hF, 32'h1122_3344, 1'b1, rd);
    classic("wr byte0", wa(4), 1'b1, 4'h1, 32'h0000_00AA, 1'b1, rd);
    classic("rd byte0", wa(4), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd byte0 data", rd, 32'h1122_33AA);
    classic("wr sel0", wa(4), 1'b1, 4'h0, 32'hFFFF_FFFF, 1'b1, rd);
    classic("rd sel0", wa(4), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd sel0 data", rd, 32'h1122_33AA);

    // Strobe held with cti=001 (classic): one ack, a gap, then a fresh access
    drive(wa(4), 1'b0, 4'h0, 32'h0, 3'b001, BTE_LINEAR);
    step();
    chk("held ack1", 32'(bus.wb_ack_o), 32'd1);
    chk("held dat1", bus.wb_dat_o, 32'h1122_33AA);
    step();
    chk("held gap", 32'(bus.wb_ack_o), 32'd0);
    step();
    chk("held ack2", 32'(bus.wb_ack_o), 32'd1);
    release_bus();
    step();
    chk("held busy end", 32'(busy), 32'd0);

    // Wrap4 read burst from idx 6
    for (int i = 4; i < 8; i++) classic("pre wrap", wa(i), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i), 1'b1, rd);
    drive(wa(6), 1'b0, 4'h0, 32'h0, CTI_INCR, BTE_WRAP4);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.wb_cti_i = CTI_EOB;
      step();
      chk("wrap4 ack", 32'(bus.wb_ack_o), 32'd1);
      chk("wrap4 dat", bus.wb_dat_o, 32'hC0DE_0000 + 32'(exp_idx[i]));
      chk("wrap4 rty", 32'(bus.wb_rty_o), 32'd0);
    end
    chk("wrap4 idle after eob", 32'(busy), 32'd0);
    release_bus();
    step();
    chk("wrap4 ack drop", 32'(bus.wb_ack_o), 32'd0);

    // Linear write burst running off the end of the RAM
    classic("pre w0", wa(0), 1'b1, 4'hF, 32'h0BAD_F00D, 1'b1, rd);
    classic("pre w255", wa(255), 1'b1, 4'hF, 32'h5555_5555, 1'b1, rd);
    drive(wa(DEPTH - 2), 1'b1, 4'hF, 32'h1111_0001, CTI_INCR, BTE_LINEAR);
    step();
    chk("lin b0 ack", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'b10);
    bus.wb_dat_i = 32'h1111_0002;
    step();
    chk("lin b1 ack", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'b10);
    bus.wb_dat_i = 32'h1111_0003;
    bus.wb_cti_i = CTI_EOB;
    step();
    chk("lin b2 err", 32'({bus.wb_ack_o, bus.wb_err_o}), 32'b01);
    chk("lin b2 dat", bus.wb_dat_o, 32'd0);
    chk("lin b2 busy", 32'(busy), 32'd0);
    release_bus();
    step();
    chk("lin err drop", 32'(bus.wb_err_o), 32'd0);
    classic("rd w254", wa(254), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd w254 data", rd, 32'h1111_0001);
    classic("rd w255", wa(255), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd w255 data", rd, 32'h1111_0002);
    classic("rd w0", wa(0), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd w0 no wrap", rd, 32'h0BAD_F00D);

    // Out-of-window accesses above and below the RAM
    classic("oor above", wa(DEPTH), 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    chk("oor above dat", rd, 32'd0);
    classic("oor below", BASE - 32'd4, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, rd);
    classic("rd w0 after oor", wa(0), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd w0 after oor data", rd, 32'h0BAD_F00D);

    // Reset during the second beat of a write burst
    classic("pre w11", wa(11), 1'b1, 4'hF, 32'h7777_7777, 1'b1, rd);
    drive(wa(10), 1'b1, 4'hF, 32'hA5A5_A5A5, CTI_INCR, BTE_LINEAR);
    step();
    chk("rst b0 ack", 32'(bus.wb_ack_o), 32'd1);
    bus.wb_dat_i = 32'hBBBB_BBBB;
    rst = 1'b1;
    step();
    chk("rst ack/err/busy", 32'({bus.wb_ack_o, bus.wb_err_o, busy}), 32'd0);
    rst = 1'b0;
    release_bus();
    step();
    classic("rd w10", wa(10), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd w10 kept", rd, 32'hA5A5_A5A5);
    classic("rd w11", wa(11), 1'b0, 4'h0, 32'h0, 1'b1, rd);
    chk("rd w11 unwritten", rd, 32'h7777_7777);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
